// File: rtl/player_action_encoder.sv
// -----------------------------------------------------------------------------
// player_action_encoder
//
// Turns one player's raw push-buttons into a one-hot action code, one action
// per game tick. The path is: 2-flop synchroniser, per-button debounce,
// rising-edge detection, press latching between ticks, priority selection at
// the tick, and an attack cooldown that blocks PUNCH/KICK for a few ticks
// after one has been emitted.
//
// Button / action bit order: {MOVE_RIGHT, MOVE_LEFT, WAIT, JUMP, KICK, PUNCH}.
// JUMP/KICK/PUNCH act on a press edge only. MOVE_LEFT/MOVE_RIGHT/WAIT also act
// while held at the tick.
//
// Optional build macro:
//   ACTION_FIFO_EN  replaces the sticky pending mask with a 4-entry in-order
//                   queue of edge-only presses (one entry popped per tick) and
//                   enables the sticky overflow flag action_ovf.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synchronised samples before a
//                    button's stable level follows them (>= 1)
//   COOLDOWN_TICKS   ticks after an emitted PUNCH/KICK during which further
//                    PUNCH/KICK are blocked (0 disables the cooldown)
//   MIRROR           1 swaps MOVE_LEFT/MOVE_RIGHT at the output
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   btn_raw[5:0]    raw asynchronous button levels
//   tick            one-cycle game-step strobe
//   action_out[5:0] one-hot action chosen at the last tick (000000 = idle)
//   action_valid    pulses on the cycle action_out is updated
//   attack_blocked  pulses when a PUNCH/KICK was discarded by the cooldown
//   action_ovf      sticky queue overflow (constant 0 without ACTION_FIFO_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module player_action_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_TICKS  = 2,
    parameter bit MIRROR          = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn_raw,
    input  logic       tick,
    output logic [5:0] action_out,
    output logic       action_valid,
    output logic       attack_blocked,
    output logic       action_ovf
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CDW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CDW-1:0] CD_INIT    = CDW'(COOLDOWN_TICKS);
    localparam logic [5:0]     LEVEL_MASK  = 6'b111000;
    localparam logic [5:0]     ATTACK_MASK = 6'b000011;

    typedef enum logic {
        ST_READY    = 1'b0,
        ST_COOLDOWN = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce and press-edge detection
    // -------------------------------------------------------------------------
    logic [DBW-1:0] r_db_cnt [6];
    logic [5:0]     r_stable;
    logic [5:0]     r_stable_d;
    logic [5:0]     w_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_stable   <= '0;
            r_stable_d <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < 6; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    // This differing sample is the DEBOUNCE_CYCLES-th in a row.
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Held high for exactly one cycle after the stable level rises.
    assign w_press = r_stable & ~r_stable_d;

    // -------------------------------------------------------------------------
    // Press latching between ticks -> candidate set seen at the tick
    // -------------------------------------------------------------------------
    logic [5:0] w_cand;

`ifdef ACTION_FIFO_EN
    // Each cycle's edge-only presses form one queue entry; simultaneous
    // presses share an entry and are resolved by priority when popped.
    logic [2:0] r_q_mem [4];
    logic [1:0] r_q_rd;
    logic [1:0] r_q_wr;
    logic [2:0] r_q_cnt;
    logic       r_ovf;
    logic [2:0] w_push_mask;
    logic [2:0] w_head;
    logic       w_push;
    logic       w_q_empty;
    logic       w_q_full;
    logic       w_pop;
    logic       w_bypass;
    logic       w_store;

    assign w_push_mask = w_press[2:0];
    assign w_push      = |w_push_mask;
    assign w_q_empty   = (r_q_cnt == 3'd0);
    assign w_q_full    = (r_q_cnt == 3'd4);
    assign w_pop       = tick && !w_q_empty;
    // An empty queue hands a press arriving on the tick cycle straight through.
    assign w_bypass    = tick && w_q_empty && w_push;
    // A pop on a full queue frees the slot the simultaneous push then takes.
    assign w_store     = w_push && !w_bypass && (!w_q_full || w_pop);
    assign w_head      = w_pop    ? r_q_mem[r_q_rd] :
                         w_bypass ? w_push_mask     : 3'b000;
    assign w_cand      = {r_stable[5:3], w_head};

    // NOTE: the queue storage is not reset; the count and pointers decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_q_mem[r_q_wr] <= w_push_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_q_cnt <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_q_rd <= r_q_rd + 1'b1;
            end
            if (w_store) begin
                r_q_wr <= r_q_wr + 1'b1;
            end
            r_q_cnt <= r_q_cnt + {2'b00, w_store} - {2'b00, w_pop};
            if (w_push && w_q_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign action_ovf = r_ovf;
`else
    logic [5:0] r_pending;

    // A press on the tick cycle is folded into this tick, and everything
    // pending is dropped at the tick whether or not it was chosen.
    assign w_cand = r_pending | w_press | (r_stable & LEVEL_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (tick) begin
            r_pending <= '0;
        end else begin
            r_pending <= r_pending | w_press;
        end
    end

    assign action_ovf = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Selection: PUNCH > KICK > JUMP > MOVE_LEFT > MOVE_RIGHT > WAIT,
    // with opposing moves cancelling each other.
    // -------------------------------------------------------------------------
    function automatic logic [5:0] f_select(input logic [5:0] cand);
        logic [5:0] m;
        m = cand;
        if (m[5] && m[4]) begin
            m[5:4] = 2'b00;
        end
        f_select = 6'b000000;
        if      (m[0]) f_select = 6'b000001;
        else if (m[1]) f_select = 6'b000010;
        else if (m[2]) f_select = 6'b000100;
        else if (m[4]) f_select = 6'b010000;
        else if (m[5]) f_select = 6'b100000;
        else if (m[3]) f_select = 6'b001000;
    endfunction

    // -------------------------------------------------------------------------
    // Cooldown FSM
    // -------------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic [CDW-1:0] r_cd_cnt;
    logic [CDW-1:0] w_cd_next;
    logic [5:0]     w_eff;
    logic [5:0]     w_sel;
    logic [5:0]     w_out;
    logic           w_blocked;
    logic [5:0]     r_action;
    logic           r_valid;
    logic           r_blocked;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cd_next    = r_cd_cnt;
        w_blocked    = 1'b0;
        w_eff        = w_cand;
        w_sel        = 6'b000000;
        if (tick) begin
            if (r_state == ST_COOLDOWN) begin
                w_eff     = w_cand & ~ATTACK_MASK;
                w_blocked = |(w_cand & ATTACK_MASK);
                w_cd_next = r_cd_cnt - 1'b1;
                // Still masked on the tick that empties the counter.
                if (r_cd_cnt == CDW'(1)) begin
                    w_state_next = ST_READY;
                end
            end
            w_sel = f_select(w_eff);
            if ((r_state == ST_READY) && (|(w_sel & ATTACK_MASK)) &&
                (COOLDOWN_TICKS > 0)) begin
                w_state_next = ST_COOLDOWN;
                w_cd_next    = CD_INIT;
            end
        end
    end

    // Mirroring happens after selection so priority keeps the un-mirrored order.
    assign w_out = MIRROR ? {w_sel[4], w_sel[5], w_sel[3:0]} : w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_READY;
            r_cd_cnt  <= '0;
            r_action  <= '0;
            r_valid   <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cd_cnt  <= w_cd_next;
            r_valid   <= tick;
            r_blocked <= w_blocked;
            if (tick) begin
                r_action <= w_out;
            end
        end
    end

    assign action_out     = r_action;
    assign action_valid   = r_valid;
    assign attack_blocked = r_blocked;

endmodule

// File: tb/tb_player_action_encoder.sv
`timescale 1ns/1ps

module tb_player_action_encoder;

    localparam logic [5:0] B_0 = 6'b000000;
    localparam logic [5:0] B_R = 6'b100000;
    localparam logic [5:0] B_L = 6'b010000;
    localparam logic [5:0] B_W = 6'b001000;
    localparam logic [5:0] B_J = 6'b000100;
    localparam logic [5:0] B_K = 6'b000010;
    localparam logic [5:0] B_P = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [5:0] btn_raw;

    logic [5:0] action_out;
    logic       action_valid;
    logic       attack_blocked;
    logic       action_ovf;
    logic [5:0] action_out_m;
    logic       action_valid_m;
    logic       attack_blocked_m;
    logic       action_ovf_m;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    player_action_encoder #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_TICKS (2),
        .MIRROR         (1'b0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .tick          (tick),
        .action_out    (action_out),
        .action_valid  (action_valid),
        .attack_blocked(attack_blocked),
        .action_ovf    (action_ovf)
    );

    // Right-side player: same stimulus, MOVE bits swapped at the output.
    player_action_encoder #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_TICKS (2),
        .MIRROR         (1'b1)
    ) dut_m (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .tick          (tick),
        .action_out    (action_out_m),
        .action_valid  (action_valid_m),
        .attack_blocked(attack_blocked_m),
        .action_ovf    (action_ovf_m)
    );

    typedef struct {
        string      name;
        logic [5:0] press;    // pressed and released before the tick
        logic [5:0] hold;     // held across the tick
        logic [5:0] exp_out;
        logic       exp_blk;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] f_mirror(input logic [5:0] a);
        return {a[4], a[5], a[3:0]};
    endfunction

    task automatic press(input logic [5:0] m);
        if (m != B_0) begin
            btn_raw = btn_raw | m;
            cyc(8);
            btn_raw = btn_raw & ~m;
            cyc(8);
        end
    endtask

    task automatic tick_check(input string name, input logic [5:0] exp_out, input logic exp_blk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check({name, ".out"},     32'(action_out),     32'(exp_out));
        check({name, ".valid"},   32'(action_valid),   32'd1);
        check({name, ".blocked"}, 32'(attack_blocked), 32'(exp_blk));
        check({name, ".mirror"},  32'(action_out_m),   32'(f_mirror(exp_out)));
        cyc(1);
        check({name, ".valid_drop"}, 32'(action_valid), 32'd0);
        check({name, ".out_hold"},   32'(action_out),   32'(exp_out));
    endtask

    initial begin
        // Cooldown state carries from row to row; see comments on the right.
        vecs[0]  = '{"idle",            B_0,       B_0,             B_0, 1'b0};
        vecs[1]  = '{"wait_level",      B_0,       B_W,             B_W, 1'b0};
        vecs[2]  = '{"move_right",      B_0,       B_R,             B_R, 1'b0};
        vecs[3]  = '{"move_left",       B_0,       B_L,             B_L, 1'b0};
        vecs[4]  = '{"moves_cancel",    B_0,       B_R | B_L | B_W, B_W, 1'b0};
        vecs[5]  = '{"moves_only",      B_0,       B_R | B_L,       B_0, 1'b0};
        vecs[6]  = '{"jump_press",      B_J,       B_0,             B_J, 1'b0};
        vecs[7]  = '{"jump_over_move",  B_J,       B_L,             B_J, 1'b0};
        vecs[8]  = '{"kick_press",      B_K,       B_0,             B_K, 1'b0}; // -> cooldown 2
        vecs[9]  = '{"cd_punch_block",  B_P,       B_0,             B_0, 1'b1}; // cd 1
        vecs[10] = '{"cd_kick_jump",    B_K | B_J, B_0,             B_J, 1'b1}; // ready
        vecs[11] = '{"punch_over_kick", B_P | B_K, B_0,             B_P, 1'b0}; // -> cooldown 2
        vecs[12] = '{"cd_move_left",    B_0,       B_L,             B_L, 1'b0}; // cd 1
        vecs[13] = '{"cd_move_right",   B_0,       B_R,             B_R, 1'b0}; // ready
        vecs[14] = '{"kick_over_wait",  B_K,       B_W,             B_K, 1'b0}; // -> cooldown 2
        vecs[15] = '{"cd_idle_a",       B_0,       B_0,             B_0, 1'b0}; // cd 1
        vecs[16] = '{"cd_idle_b",       B_0,       B_0,             B_0, 1'b0}; // ready

        rst_n   = 1'b0;
        tick    = 1'b0;
        btn_raw = B_0;
        #2;
        check("rst.out",     32'(action_out),     32'd0);
        check("rst.valid",   32'(action_valid),   32'd0);
        check("rst.blocked", 32'(attack_blocked), 32'd0);
        check("rst.ovf",     32'(action_ovf),     32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        check("post_rst.out",   32'(action_out),   32'd0);
        check("post_rst.valid", 32'(action_valid), 32'd0);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].press);
            btn_raw = btn_raw | vecs[i].hold;
            cyc(8);
            tick_check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_blk);
            btn_raw = btn_raw & ~vecs[i].hold;
            cyc(8);
        end

        // Single-cycle glitch never reaches the stable level.
        btn_raw = B_P;
        cyc(1);
        btn_raw = B_0;
        cyc(10);
        tick_check("glitch_punch", B_0, 1'b0);

        // KICK pressed and released well before the tick.
        btn_raw = B_K;
        cyc(10);
        btn_raw = B_0;
        cyc(20);
        tick_check("kick_release", B_K, 1'b0);
        tick_check("kick_cd1",     B_0, 1'b0);
        tick_check("kick_cd2",     B_0, 1'b0);

        // KICK held across several ticks: one action only, no repeat.
        btn_raw = B_K;
        cyc(10);
        tick_check("kick_held",          B_K, 1'b0);
        tick_check("kick_held_cd1",      B_0, 1'b0);
        tick_check("kick_held_cd2",      B_0, 1'b0);
        tick_check("kick_held_norepeat", B_0, 1'b0);
        btn_raw = B_0;
        cyc(8);

        // tick high for two cycles: two ticks, pending cleared by the first.
        press(B_J);
        tick = 1'b1;
        @(posedge clk);
        #1;
        check("tick2.first_out",    32'(action_out),   32'(B_J));
        check("tick2.first_valid",  32'(action_valid), 32'd1);
        @(posedge clk);
        #1;
        tick = 1'b0;
        check("tick2.second_out",   32'(action_out),   32'(B_0));
        check("tick2.second_valid", 32'(action_valid), 32'd1);
        cyc(1);
        check("tick2.valid_drop",   32'(action_valid), 32'd0);

        // Press edge lands on the tick cycle: 2 sync + 4 debounce edges after
        // the raw change, the edge is visible when the 7th edge samples tick.
        btn_raw = B_J;
        repeat (6) @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check("same_cycle.out",   32'(action_out),   32'(B_J));
        check("same_cycle.valid", 32'(action_valid), 32'd1);
        btn_raw = B_0;
        cyc(8);
        tick_check("same_cycle_next", B_0, 1'b0);

        // MOVE_LEFT + PUNCH held through the cooldown, then PUNCH re-pressed.
        btn_raw = B_L | B_P;
        cyc(8);
        tick_check("mlp_punch", B_P, 1'b0);
        tick_check("mlp_cd1",   B_L, 1'b0);
        tick_check("mlp_cd2",   B_L, 1'b0);
        btn_raw = B_L;
        cyc(8);
        btn_raw = B_L | B_P;
        cyc(8);
        tick_check("mlp_repunch", B_P, 1'b0);
        btn_raw = B_0;
        cyc(8);
        tick_check("mlp_cd_a", B_0, 1'b0);
        tick_check("mlp_cd_b", B_0, 1'b0);

`ifdef ACTION_FIFO_EN
        // Four entries fill the queue; the fifth press overflows.
        press(B_J);
        press(B_K);
        press(B_J);
        press(B_J);
        check("fifo.ovf_before", 32'(action_ovf), 32'd0);
        press(B_P);
        check("fifo.ovf_set", 32'(action_ovf), 32'd1);
        tick_check("fifo_pop1",  B_J, 1'b0);
        tick_check("fifo_pop2",  B_K, 1'b0);
        tick_check("fifo_pop3",  B_J, 1'b0);
        tick_check("fifo_pop4",  B_J, 1'b0);
        tick_check("fifo_empty", B_0, 1'b0);
        check("fifo.ovf_sticky", 32'(action_ovf), 32'd1);
`endif

        // Asynchronous reset mid-operation, button held through it.
        btn_raw = B_J;
        cyc(8);
        tick_check("pre_reset_jump", B_J, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst.out",     32'(action_out),     32'd0);
        check("mid_rst.out_m",   32'(action_out_m),   32'd0);
        check("mid_rst.valid",   32'(action_valid),   32'd0);
        check("mid_rst.blocked", 32'(attack_blocked), 32'd0);
        check("mid_rst.ovf",     32'(action_ovf),     32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        tick_check("post_reset_rejump", B_J, 1'b0);
        btn_raw = B_0;
        cyc(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
